// File: rtl/drop_sequencer_if.sv
// Drop sequencer interface: move request, renderer handshake, board-RAM
// write port and game status lines.
interface drop_sequencer_if;
  logic       go;
  logic [2:0] column;
  logic       draw_done;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [1:0] wr_data;
  logic       draw_req;
  logic [1:0] player;
  logic       busy;
  logic       illegal;
  logic [5:0] move_count;
  logic       board_full;

  // Sequencer side
  modport slave (
    input  go, column, draw_done,
    output wr_en, wr_addr, wr_data, draw_req, player,
           busy, illegal, move_count, board_full
  );

  // Controller / renderer side
  modport master (
    output go, column, draw_done,
    input  wr_en, wr_addr, wr_data, draw_req, player,
           busy, illegal, move_count, board_full
  );
endinterface

// File: rtl/drop_sequencer.sv
// Drop sequencer: accepts a column, checks it against per-column heights,
// writes the piece into board RAM, waits for the renderer, then hands the
// turn to the other player. All outputs come straight from flops.
module drop_sequencer #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic             clk,
  input  logic             reset,
  drop_sequencer_if.slave  bus
);

  localparam logic [2:0] COLS_L     = 3'(COLS);
  localparam logic [2:0] ROWS_L     = 3'(ROWS);
  localparam logic [5:0] FULL_COUNT = 6'(COLS * ROWS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_WRITE  = 3'd2,
    S_DRAW   = 3'd3,
    S_SWITCH = 3'd4,
    S_FULL   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] col_q, col_d;
  // Sized to the full 3-bit column range so an out-of-range column never
  // indexes past the array; entries at COLS and above stay at zero.
  logic [2:0] height_q [8];
  logic [1:0] player_q, player_d;
  logic [5:0] count_q, count_d;
  logic [5:0] addr_q, addr_d;
  logic       illegal_q, illegal_d;
  logic       wr_en_q, draw_req_q, busy_q, full_q;
  logic       inc_s;

  // Next-state and datapath decisions for the move sequence
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    player_d  = player_q;
    count_d   = count_q;
    addr_d    = addr_q;
    illegal_d = 1'b0;
    inc_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          col_d   = bus.column;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (col_q >= COLS_L) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else if (height_q[col_q] == ROWS_L) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          addr_d  = {height_q[col_q], col_q};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        inc_s   = 1'b1;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (bus.draw_done) begin
          state_d = S_SWITCH;
        end else begin
          state_d = S_DRAW;
        end
      end
      S_SWITCH: begin
        player_d = (player_q == 2'b01) ? 2'b10 : 2'b01;
        count_d  = count_q + 6'd1;
        if (count_d == FULL_COUNT) begin
          state_d = S_FULL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FULL: begin
        state_d = S_FULL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, game registers and output flops; reset wins over any input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= 3'd0;
      player_q   <= 2'b01;
      count_q    <= 6'd0;
      addr_q     <= 6'd0;
      illegal_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      draw_req_q <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        height_q[i] <= 3'd0;
      end
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      player_q   <= player_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      illegal_q  <= illegal_d;
      wr_en_q    <= (state_d == S_WRITE);
      draw_req_q <= (state_d == S_DRAW);
      busy_q     <= (state_d != S_IDLE);
      full_q     <= (state_d == S_FULL);
      if (inc_s) begin
        height_q[col_q] <= height_q[col_q] + 3'd1;
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = player_q;
  assign bus.draw_req   = draw_req_q;
  assign bus.player     = player_q;
  assign bus.busy       = busy_q;
  assign bus.illegal    = illegal_q;
  assign bus.move_count = count_q;
  assign bus.board_full = full_q;

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer: directed scenarios plus a random
// game fill, checked against a board model (column heights, turn, count).
module tb_drop_sequencer;

  logic clk;
  logic reset;
  drop_sequencer_if bus ();

  drop_sequencer #(.COLS(7), .ROWS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the game
  int         m_h [8];
  logic [1:0] m_player;
  int         m_count;
  bit         m_full;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_h[i] = 0;
    m_player = 2'b01;
    m_count  = 0;
    m_full   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if ({bus.wr_en, bus.draw_req, bus.illegal, bus.busy, bus.board_full} !== 5'b0) begin
      miscompares++;
      $display("FAIL %s flags got %b required 00000", tag,
               {bus.wr_en, bus.draw_req, bus.illegal, bus.busy, bus.board_full});
    end
    vectors++;
    if (bus.player !== 2'b01 || bus.move_count !== 6'd0) begin
      miscompares++;
      $display("FAIL %s player/count got %b/%0d required 01/0", tag, bus.player, bus.move_count);
    end
  endtask

  task automatic test_reset();
    bus.go = 1'b0; bus.column = 3'd0; bus.draw_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset");
  endtask

  // One move request from IDLE; checks every cycle against the model.
  task automatic run_move(input logic [2:0] col, input int delay, input bit hold_go);
    bit         legal;
    int         wr_pulses;
    logic [5:0] exp_addr;
    wr_pulses = 0;
    legal = (col < 3'd7) && (m_h[col] < 6);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_busy got %b required 0", bus.busy);
    end
    bus.go = 1'b1; bus.column = col;
    @(negedge clk);                        // CHECK cycle
    if (!hold_go || !legal) bus.go = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.wr_en !== 1'b0 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL check_cycle busy/wr_en/illegal got %b%b%b required 100", bus.busy, bus.wr_en, bus.illegal);
    end
    @(negedge clk);
    if (!legal) begin
      vectors++;
      if (bus.illegal !== 1'b1 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_pulse illegal/wr_en/busy got %b%b%b required 100", bus.illegal, bus.wr_en, bus.busy);
      end
      @(negedge clk);
      vectors++;
      if (bus.illegal !== 1'b0 || bus.player !== m_player || bus.move_count !== 6'(m_count)) begin
        miscompares++;
        $display("FAIL illegal_after illegal/player/count got %b/%b/%0d required 0/%b/%0d",
                 bus.illegal, bus.player, bus.move_count, m_player, m_count);
      end
      return;
    end
    exp_addr = {3'(m_h[col]), col};
    if (bus.wr_en === 1'b1) wr_pulses++;
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== m_player) begin
      miscompares++;
      $display("FAIL write wr_en/addr/data got %b/%b/%b required 1/%b/%b",
               bus.wr_en, bus.wr_addr, bus.wr_data, exp_addr, m_player);
    end
    m_h[col]++;
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);                      // DRAW cycles
      if (bus.wr_en === 1'b1) wr_pulses++;
      vectors++;
      if (bus.draw_req !== 1'b1 || bus.wr_addr !== exp_addr || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL draw_hold draw_req/addr/busy got %b/%b/%b required 1/%b/1",
                 bus.draw_req, bus.wr_addr, bus.busy, exp_addr);
      end
    end
    bus.draw_done = 1'b1;
    bus.go = 1'b0;
    @(negedge clk);                        // SWITCH cycle
    bus.draw_done = 1'b0;
    if (bus.wr_en === 1'b1) wr_pulses++;
    vectors++;
    if (bus.draw_req !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL switch draw_req/busy got %b/%b required 0/1", bus.draw_req, bus.busy);
    end
    m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
    m_count++;
    m_full = (m_count == 42);
    @(negedge clk);
    if (bus.wr_en === 1'b1) wr_pulses++;
    vectors++;
    if (bus.player !== m_player || bus.move_count !== 6'(m_count) ||
        bus.board_full !== m_full || bus.busy !== m_full) begin
      miscompares++;
      $display("FAIL after_move player/count/full/busy got %b/%0d/%b/%b required %b/%0d/%b/%b",
               bus.player, bus.move_count, bus.board_full, bus.busy, m_player, m_count, m_full, m_full);
    end
    vectors++;
    if (wr_pulses != 1) begin
      miscompares++; $display("FAIL wr_pulses got %0d required 1", wr_pulses);
    end
  endtask

  task automatic test_first_move();
    run_move(3'd3, 3, 1'b0);
  endtask

  task automatic test_column_full();
    test_reset();
    for (int i = 0; i < 6; i++) run_move(3'd0, int'($urandom_range(0, 3)), 1'b0);
    run_move(3'd0, 0, 1'b0);
  endtask

  task automatic test_bad_column();
    run_move(3'd7, 0, 1'b0);
  endtask

  task automatic test_go_held();
    run_move(3'($urandom_range(1, 6)), 10, 1'b1);
  endtask

  task automatic test_draw_done_idle();
    bus.draw_done = 1'b1;
    repeat (2) @(negedge clk);
    bus.draw_done = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.draw_req !== 1'b0 || bus.move_count !== 6'(m_count)) begin
      miscompares++;
      $display("FAIL draw_done_idle busy/draw_req/count got %b/%b/%0d required 0/0/%0d",
               bus.busy, bus.draw_req, bus.move_count, m_count);
    end
  endtask

  task automatic test_reset_mid_draw();
    logic [2:0] col;
    col = 3'($urandom_range(0, 6));
    run_move(col, 0, 1'b0);                // give the column some height
    bus.go = 1'b1; bus.column = col;
    repeat (3) @(negedge clk);             // CHECK, WRITE, DRAW
    bus.go = 1'b1;
    vectors++;
    if (bus.draw_req !== 1'b1) begin
      miscompares++; $display("FAIL mid_draw_req got %b required 1", bus.draw_req);
    end
    reset = 1'b1; bus.draw_done = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_in_draw");
    reset = 1'b0; bus.go = 1'b0; bus.draw_done = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("after_reset_idle");
    run_move(col, 1, 1'b0);                // must land in row 0 again
  endtask

  task automatic test_random_fill();
    int iters;
    test_reset();
    iters = 0;
    while (m_count < 42 && iters < 3000) begin
      run_move(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      iters++;
    end
    vectors++;
    if (m_count != 42) begin
      miscompares++; $display("FAIL fill_budget moves got %0d required 42", m_count);
    end
    bus.column = 3'd0;
    for (int i = 0; i < 12; i++) begin
      bus.go = 1'b1;
      bus.draw_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (bus.wr_en !== 1'b0 || bus.board_full !== 1'b1 || bus.busy !== 1'b1 ||
          bus.move_count !== 6'd42 || bus.draw_req !== 1'b0) begin
        miscompares++;
        $display("FAIL full_hold wr_en/full/busy/count/draw_req got %b/%b/%b/%0d/%b required 0/1/1/42/0",
                 bus.wr_en, bus.board_full, bus.busy, bus.move_count, bus.draw_req);
      end
    end
    bus.go = 1'b0; bus.draw_done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_outputs("reset_from_full");
  endtask

  initial begin
    reset = 1'b1;
    bus.go = 1'b0; bus.column = 3'd0; bus.draw_done = 1'b0;
    test_reset();
    test_first_move();
    test_draw_done_idle();
    test_bad_column();
    test_go_held();
    test_column_full();
    test_reset_mid_draw();
    test_random_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
